// File: rtl/commit_stage.sv
// rtl/commit_stage.sv - multi-lane in-order commit stage with precise exceptions and CP0 Count/Compare timer
//
// Purpose: registers one bundle of LANES instructions from the memory stage and
// retires it in program order (lane 0 oldest). The oldest valid lane carrying an
// exception or ERET squashes itself and every younger lane. The stage drives the
// GPR write ports and the fetch redirect (flush), and owns CP0 Count/Compare,
// Cause.TI and Cause.IP.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         bundle handshake from the memory stage
//   in_lane_valid .. in_wr_compare  per-lane instruction fields (lane k at slice k)
//   ext_int, status_*           interrupt lines and Status.IM/IE/EXL
//   rf_we / rf_waddr / rf_wdata GPR write ports, one per lane
//   exc_valid/exc_code/exc_epc  committed exception
//   eret_valid, flush           committed ERET, redirect request
//   count, compare, cause_ip, timer_int, irq_req  CP0 timer and interrupt state
module commit_stage #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int COUNT_DIV = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES*XLEN-1:0]    in_pc,
    input  logic [LANES-1:0]         in_wr_en,
    input  logic [LANES*REG_AW-1:0]  in_wr_dst,
    input  logic [LANES*XLEN-1:0]    in_wr_data,
    input  logic [LANES-1:0]         in_exc,
    input  logic [LANES*5-1:0]       in_exc_code,
    input  logic [LANES-1:0]         in_eret,
    input  logic [LANES-1:0]         in_wr_count,
    input  logic [LANES-1:0]         in_wr_compare,
    input  logic [5:0]               ext_int,
    input  logic [7:0]               status_im,
    input  logic                     status_ie,
    input  logic                     status_exl,
    output logic [LANES-1:0]         rf_we,
    output logic [LANES*REG_AW-1:0]  rf_waddr,
    output logic [LANES*XLEN-1:0]    rf_wdata,
    output logic                     exc_valid,
    output logic [4:0]               exc_code,
    output logic [XLEN-1:0]          exc_epc,
    output logic                     eret_valid,
    output logic                     flush,
    output logic [XLEN-1:0]          count,
    output logic [XLEN-1:0]          compare,
    output logic [7:0]               cause_ip,
    output logic                     timer_int,
    output logic                     irq_req
);

    // Prescaler needs at least one bit even when COUNT_DIV == 1.
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;
    state_t state_q, state_d;

    // Stage register
    logic                    valid_q, valid_d;
    logic [LANES-1:0]        lv_q, lv_d, wen_q, wen_d, exc_q, exc_d;
    logic [LANES-1:0]        eret_q, eret_d, wcnt_q, wcnt_d, wcmp_q, wcmp_d;
    logic [LANES*XLEN-1:0]   pc_q, pc_d, data_q, data_d;
    logic [LANES*REG_AW-1:0] dst_q, dst_d;
    logic [LANES*5-1:0]      code_q, code_d;

    // CP0 timer / interrupt state
    logic [XLEN-1:0] count_q, count_d, compare_q, compare_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            ti_q, ti_d;
    logic [5:0]      ext_q, ext_d;

    // Lane-ordered Count/Compare write requests from committed lanes
    logic            cnt_wr, cmp_wr, squashed, tick;
    logic [XLEN-1:0] cnt_wdata, cmp_wdata, count_inc;

    // FSM: a committed flush holds off upstream for exactly one cycle.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == ST_RUN);
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Bundle capture; an unaccepted cycle loads a bubble.
    always_comb begin
        valid_d = in_valid & in_ready;
        lv_d    = lv_q;   pc_d   = pc_q;   wen_d  = wen_q;  dst_d  = dst_q;
        data_d  = data_q; exc_d  = exc_q;  code_d = code_q; eret_d = eret_q;
        wcnt_d  = wcnt_q; wcmp_d = wcmp_q;
        if (valid_d) begin
            lv_d   = in_lane_valid; pc_d   = in_pc;       wen_d  = in_wr_en;
            dst_d  = in_wr_dst;     data_d = in_wr_data;  exc_d  = in_exc;
            code_d = in_exc_code;   eret_d = in_eret;     wcnt_d = in_wr_count;
            wcmp_d = in_wr_compare;
        end
    end

    // Commit: walk lanes oldest first; the first exc/eret lane stops all later
    // writes. Later committed lanes overwrite earlier Count/Compare requests so
    // the youngest one wins.
    always_comb begin
        rf_we      = '0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        exc_valid  = 1'b0;
        exc_code   = '0;
        exc_epc    = '0;
        eret_valid = 1'b0;
        cnt_wr     = 1'b0;
        cnt_wdata  = '0;
        cmp_wr     = 1'b0;
        cmp_wdata  = '0;
        squashed   = 1'b0;
        if (valid_q) begin
            for (int k = 0; k < LANES; k++) begin
                if (!squashed && lv_q[k]) begin
                    if (exc_q[k]) begin
                        exc_valid = 1'b1;
                        exc_code  = code_q[k*5 +: 5];
                        exc_epc   = pc_q[k*XLEN +: XLEN];
                        squashed  = 1'b1;
                    end else if (eret_q[k]) begin
                        eret_valid = 1'b1;
                        squashed   = 1'b1;
                    end else begin
                        if (wen_q[k] && (dst_q[k*REG_AW +: REG_AW] != '0)) begin
                            rf_we[k]                       = 1'b1;
                            rf_waddr[k*REG_AW +: REG_AW]   = dst_q[k*REG_AW +: REG_AW];
                            rf_wdata[k*XLEN +: XLEN]       = data_q[k*XLEN +: XLEN];
                        end
                        if (wcnt_q[k]) begin
                            cnt_wr    = 1'b1;
                            cnt_wdata = data_q[k*XLEN +: XLEN];
                        end
                        if (wcmp_q[k]) begin
                            cmp_wr    = 1'b1;
                            cmp_wdata = data_q[k*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    assign flush = exc_valid | eret_valid;

    // Timer. A Count write suppresses the increment (so no match that cycle);
    // a Compare write clears TI even if Count matches in the same cycle.
    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        count_inc = count_q + XLEN'(1);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        count_d   = tick ? count_inc : count_q;
        compare_d = compare_q;
        ti_d      = ti_q | (tick && (count_inc == compare_q));
        ext_d     = ext_int;
        if (cnt_wr) begin
            count_d = cnt_wdata;
            presc_d = '0;
            ti_d    = ti_q;
        end
        if (cmp_wr) begin
            compare_d = cmp_wdata;
            ti_d      = 1'b0;
        end
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_int = ti_q;
    assign cause_ip  = {ext_q[5] | ti_q, ext_q[4:0], 2'b00};
    assign irq_req   = status_ie & ~status_exl & (|(cause_ip & status_im));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            lv_q    <= '0; pc_q   <= '0; wen_q  <= '0; dst_q  <= '0;
            data_q  <= '0; exc_q  <= '0; code_q <= '0; eret_q <= '0;
            wcnt_q  <= '0; wcmp_q <= '0;
            count_q   <= '0;
            compare_q <= '0;
            presc_q   <= '0;
            ti_q      <= 1'b0;
            ext_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            lv_q    <= lv_d;   pc_q   <= pc_d;   wen_q  <= wen_d;  dst_q  <= dst_d;
            data_q  <= data_d; exc_q  <= exc_d;  code_q <= code_d; eret_q <= eret_d;
            wcnt_q  <= wcnt_d; wcmp_q <= wcmp_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
            ti_q      <= ti_d;
            ext_q     <= ext_d;
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// tb/tb_commit_stage.sv - self-checking bench for commit_stage (LANES=2, COUNT_DIV=2)
module tb_commit_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_lane_valid;
    logic [63:0] in_pc;
    logic [1:0]  in_wr_en;
    logic [9:0]  in_wr_dst;
    logic [63:0] in_wr_data;
    logic [1:0]  in_exc;
    logic [9:0]  in_exc_code;
    logic [1:0]  in_eret;
    logic [1:0]  in_wr_count;
    logic [1:0]  in_wr_compare;
    logic [5:0]  ext_int;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic [1:0]  rf_we;
    logic [9:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        eret_valid;
    logic        flush;
    logic [31:0] count;
    logic [31:0] compare;
    logic [7:0]  cause_ip;
    logic        timer_int;
    logic        irq_req;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    commit_stage #(.LANES(2), .XLEN(32), .REG_AW(5), .COUNT_DIV(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_wr_en(in_wr_en),
        .in_wr_dst(in_wr_dst), .in_wr_data(in_wr_data), .in_exc(in_exc),
        .in_exc_code(in_exc_code), .in_eret(in_eret), .in_wr_count(in_wr_count),
        .in_wr_compare(in_wr_compare), .ext_int(ext_int), .status_im(status_im),
        .status_ie(status_ie), .status_exl(status_exl), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_epc(exc_epc), .eret_valid(eret_valid),
        .flush(flush), .count(count), .compare(compare), .cause_ip(cause_ip),
        .timer_int(timer_int), .irq_req(irq_req)
    );

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pc;
        logic [1:0]  we;
        logic [9:0]  dst;
        logic [63:0] data;
        logic [1:0]  exc;
        logic [9:0]  code;
        logic [1:0]  eret;
        logic [1:0]  wcnt;
        logic [1:0]  wcmp;
        logic [1:0]  e_we;
        logic [9:0]  e_waddr;
        logic [63:0] e_wdata;
        logic        e_exc;
        logic [4:0]  e_code;
        logic [31:0] e_epc;
        logic        e_eret;
        logic [31:0] e_cmp;
        logic        chk_cmp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        in_lane_valid = v.lv;   in_pc       = v.pc;   in_wr_en      = v.we;
        in_wr_dst     = v.dst;  in_wr_data  = v.data; in_exc        = v.exc;
        in_exc_code   = v.code; in_eret     = v.eret; in_wr_count   = v.wcnt;
        in_wr_compare = v.wcmp;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{2'b00, 64'h0, 2'b00, 10'h0, 64'h0, 2'b00, 10'h0, 2'b00, 2'b00, 2'b00,
              2'b00, 10'h0, 64'h0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0};
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 8) begin
            step();
            n++;
        end
        if (!in_ready) chk("wait_ready_timeout", {63'h0, in_ready}, 64'h1);
    endtask

    // Send one bundle and leave the DUT with it in the stage register.
    task automatic send(input vec_t v);
        wait_ready();
        apply(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
        chk({tag, "_rf_we"}, {62'h0, rf_we}, 64'h0);
        chk({tag, "_exc_eret_flush"}, {61'h0, exc_valid, eret_valid, flush}, 64'h0);
        chk({tag, "_count"}, {32'h0, count}, 64'h0);
        chk({tag, "_compare"}, {32'h0, compare}, 64'h0);
        chk({tag, "_cause_ti_irq"}, {54'h0, cause_ip, timer_int, irq_req}, 64'h0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; in_valid = 1'b0; ext_int = '0; status_im = '0;
        status_ie = 1'b0; status_exl = 1'b0;
        apply(blank());

        //        lv     pc                           we     dst             data                       exc    code             eret   wcnt   wcmp   e_we   e_waddr         e_wdata                    exc   code   epc            eret  cmp    chk
        vecs[0] = '{2'b11, 64'h0,                       2'b11, {5'd0, 5'd3},   {32'h22, 32'h11},          2'b00, 10'h0,           2'b00, 2'b00, 2'b00, 2'b01, {5'd0, 5'd3},   {32'h0, 32'h11},           1'b0, 5'h00, 32'h0,         1'b0, 32'h0,  1'b0};
        vecs[1] = '{2'b11, {32'hBFC00104, 32'hBFC00100}, 2'b01, {5'd0, 5'd4},  {32'h0, 32'hAA},           2'b10, {5'h0C, 5'h0},   2'b00, 2'b00, 2'b00, 2'b01, {5'd0, 5'd4},   {32'h0, 32'hAA},           1'b1, 5'h0C, 32'hBFC00104,  1'b0, 32'h0,  1'b0};
        vecs[2] = '{2'b11, 64'h0,                       2'b10, {5'd5, 5'd0},   {32'h55, 32'h0},           2'b00, 10'h0,           2'b01, 2'b00, 2'b00, 2'b00, 10'h0,          64'h0,                     1'b0, 5'h00, 32'h0,         1'b1, 32'h0,  1'b0};
        vecs[3] = '{2'b11, 64'h0,                       2'b00, 10'h0,          {32'h20, 32'h10},          2'b00, 10'h0,           2'b00, 2'b00, 2'b11, 2'b00, 10'h0,          64'h0,                     1'b0, 5'h00, 32'h0,         1'b0, 32'h20, 1'b1};
        vecs[4] = '{2'b11, {32'h0, 32'h100},            2'b00, 10'h0,          {32'h99, 32'h0},           2'b01, {5'h0, 5'h04},   2'b00, 2'b00, 2'b10, 2'b00, 10'h0,          64'h0,                     1'b1, 5'h04, 32'h100,       1'b0, 32'h20, 1'b1};
        vecs[5] = '{2'b10, 64'h0,                       2'b11, {5'd7, 5'd6},   {32'h77, 32'h66},          2'b01, {5'h0, 5'h04},   2'b00, 2'b00, 2'b00, 2'b10, {5'd7, 5'd0},   {32'h77, 32'h0},           1'b0, 5'h00, 32'h0,         1'b0, 32'h0,  1'b0};
        vecs[6] = '{2'b11, {32'h0, 32'h200},            2'b11, {5'd1, 5'd2},   {32'h1, 32'h2},            2'b01, {5'h0, 5'h08},   2'b01, 2'b00, 2'b00, 2'b00, 10'h0,          64'h0,                     1'b1, 5'h08, 32'h200,       1'b0, 32'h0,  1'b0};
        vecs[7] = '{2'b11, 64'h0,                       2'b01, {5'd0, 5'd9},   {32'h0, 32'h99},           2'b00, 10'h0,           2'b10, 2'b00, 2'b00, 2'b01, {5'd0, 5'd9},   {32'h0, 32'h99},           1'b0, 5'h00, 32'h0,         1'b1, 32'h0,  1'b0};

        repeat (2) step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Table-driven commit vectors
        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            chk($sformatf("v%0d_rf_we", i), {62'h0, rf_we}, {62'h0, vecs[i].e_we});
            for (int l = 0; l < 2; l++) begin
                if (vecs[i].e_we[l]) begin
                    chk($sformatf("v%0d_waddr%0d", i, l), {59'h0, rf_waddr[l*5 +: 5]}, {59'h0, vecs[i].e_waddr[l*5 +: 5]});
                    chk($sformatf("v%0d_wdata%0d", i, l), {32'h0, rf_wdata[l*32 +: 32]}, {32'h0, vecs[i].e_wdata[l*32 +: 32]});
                end
            end
            chk($sformatf("v%0d_exc_valid", i), {63'h0, exc_valid}, {63'h0, vecs[i].e_exc});
            chk($sformatf("v%0d_eret_valid", i), {63'h0, eret_valid}, {63'h0, vecs[i].e_eret});
            chk($sformatf("v%0d_flush", i), {63'h0, flush}, {63'h0, vecs[i].e_exc | vecs[i].e_eret});
            if (vecs[i].e_exc) begin
                chk($sformatf("v%0d_exc_code", i), {59'h0, exc_code}, {59'h0, vecs[i].e_code});
                chk($sformatf("v%0d_exc_epc", i), {32'h0, exc_epc}, {32'h0, vecs[i].e_epc});
            end
            step();
            if (vecs[i].chk_cmp)
                chk($sformatf("v%0d_compare", i), {32'h0, compare}, {32'h0, vecs[i].e_cmp});
        end

        // Flush handshake: ready in the flush cycle, low one cycle, then back.
        send(vecs[1]);
        chk("flush_cycle_ready", {62'h0, in_ready, flush}, 64'h3);
        step();
        chk("flush_hold_ready", {62'h0, in_ready, flush}, 64'h0);
        step();
        chk("flush_release_ready", {63'h0, in_ready}, 64'h1);

        // Timer: Compare=4, Count=0 with prescaler restart, then 8 cycles to match.
        wait_ready();
        v = blank(); v.lv = 2'b01; v.wcmp = 2'b01; v.data = 64'h4;
        apply(v);
        in_valid = 1'b1;
        step();
        v = blank(); v.lv = 2'b01; v.wcnt = 2'b01; v.data = 64'h0;
        apply(v);
        step();
        in_valid = 1'b0;
        chk("timer_compare4", {32'h0, compare}, 64'h4);
        step();
        chk("timer_count_write", {32'h0, count}, 64'h0);
        repeat (7) step();
        chk("timer_count3", {32'h0, count}, 64'h3);
        chk("timer_ti_before", {63'h0, timer_int}, 64'h0);
        step();
        chk("timer_count4", {32'h0, count}, 64'h4);
        chk("timer_ti_set", {63'h0, timer_int}, 64'h1);
        chk("timer_cause_ip7", {63'h0, cause_ip[7]}, 64'h1);
        status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
        #1;
        chk("timer_irq", {63'h0, irq_req}, 64'h1);
        status_exl = 1'b1;
        #1;
        chk("timer_irq_exl", {63'h0, irq_req}, 64'h0);
        status_exl = 1'b0;
        v = blank(); v.lv = 2'b01; v.wcmp = 2'b01; v.data = 64'h100;
        send(v);
        step();
        chk("timer_compare100", {32'h0, compare}, 64'h100);
        chk("timer_ti_clear", {62'h0, timer_int, irq_req}, 64'h0);

        // External interrupt lines go through one register stage.
        ext_int = 6'b100001;
        #1;
        chk("ext_cause_pre", {56'h0, cause_ip}, 64'h0);
        step();
        chk("ext_cause_post", {56'h0, cause_ip}, 64'h84);
        chk("ext_irq", {63'h0, irq_req}, 64'h1);
        ext_int = '0;
        step();
        status_ie = 1'b0; status_im = '0;

        // Asynchronous reset while the FSM is in FLUSH.
        v = blank(); v.lv = 2'b01; v.wcnt = 2'b01; v.data = 64'h55;
        send(v);
        step();
        chk("rst_count55", {32'h0, count}, 64'h55);
        v = blank(); v.lv = 2'b01; v.exc = 2'b01; v.code = 10'h0C;
        send(v);
        step();
        chk("rst_in_flush", {32'h0, in_ready, count[30:0]}, 64'h56);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        step();
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
